// File: rtl/rv_pkg.sv
// Shared constants for the fetch front end: RV32 opcodes, reset PC, FSM encodings.
package rv_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] R_TYPE = 7'h33;
    localparam logic [6:0] I_TYPE = 7'h13;
    localparam logic [6:0] B_TYPE = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] JALR   = 7'h67;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Fetch FSM encodings
    localparam logic [1:0] IDLE = 2'd0;  // no request on the bus
    localparam logic [1:0] REQ  = 2'd1;  // request held until rvalid
    localparam logic [1:0] DROP = 2'd2;  // request abandoned by a redirect, swallow its response

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs. Flush wins over push/pop.
// Head outputs read zero while empty so downstream sees clean fields.
module fetch_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [AW-1:0]    push_pc_i,
    input  logic [DW-1:0]    push_instr_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [AW-1:0]    head_pc_o,
    output logic [DW-1:0]    head_instr_o
);

    logic [DW-1:0]    instr_q [DEPTH];
    logic [AW-1:0]    pc_q    [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && ((count_q < CNT_W'(DEPTH)) || do_pop);

    assign head_pc_o    = empty_o ? '0 : pc_q[rd_ptr_q];
    assign head_instr_o = empty_o ? '0 : instr_q[rd_ptr_q];

    // Storage write; contents need no reset because the head is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            instr_q[wr_ptr_q] <= push_instr_i;
            pc_q[wr_ptr_q]    <= push_pc_i;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, single-outstanding req/rvalid handshake to
// instruction memory, a small instruction buffer, and decoder field slicing.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF),
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [6:0]            op,
    output logic [2:0]            funct3,
    output logic                  funct7
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  push, pop, room;
    logic [CNT_W:0]        cnt_after;

    // Only a live (non-abandoned) response is buffered; a redirect discards it.
    assign push = (state_q == REQ) && imem_rvalid && !redirect;
    assign pop  = instr_valid && instr_ready;

    // Occupancy after this cycle's push/pop decides whether another request may go out.
    assign cnt_after = {1'b0, fifo_cnt} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
    assign room      = cnt_after < (CNT_W+1)'(FIFO_DEPTH);

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = en && !fifo_empty;
    assign op          = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[30];

    fetch_fifo #(
        .DW    (DATA_WIDTH),
        .AW    (ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect),
        .push_i       (push),
        .push_pc_i    (fetch_pc_q),
        .push_instr_i (imem_rdata),
        .pop_i        (pop),
        .empty_o      (fifo_empty),
        .count_o      (fifo_cnt),
        .head_pc_o    (instr_pc),
        .head_instr_o (instr)
    );

    // Next-state and next-PC: one request in flight, redirect always retargets the PC.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: begin
                if (en && room && !redirect) state_d = REQ;
            end
            REQ: begin
                if (redirect) begin
                    // Response already here -> simply drop it; otherwise wait it out.
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                    state_d    = (en && room) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect) fetch_pc_d = redirect_pc & ~ADDR_WIDTH'(3);
    end

    // FSM state and fetch PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a per-cycle vector table covering
// streaming, back-pressure, redirects, en gating and PC wrap, then a
// hand-written reset-mid-request sequence.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        en, rv;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic        e_chk;   // compare head fields this row
        logic [31:0] e_pc, e_instr;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] W0 = 32'h0050_0093; // addi x1,x0,5 : op 13 f3 0 f7 0
    localparam logic [31:0] W1 = 32'h4020_8133; // sub          : op 33 f3 0 f7 1
    localparam logic [31:0] W2 = 32'h0020_A023; // sw           : op 23 f3 2
    localparam logic [31:0] W3 = 32'h0000_8067; // jalr         : op 67
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    function automatic vec_t mk(logic en_, logic rv_, logic [31:0] rd_, logic rdr_,
                                logic [31:0] rpc_, logic rdy_, logic q_, logic [31:0] a_,
                                logic v_, logic c_, logic [31:0] p_, logic [31:0] i_);
        vec_t v;
        v.en = en_; v.rv = rv_; v.rdata = rd_; v.redir = rdr_; v.rpc = rpc_; v.rdy = rdy_;
        v.e_req = q_; v.e_addr = a_; v.e_vld = v_; v.e_chk = c_; v.e_pc = p_; v.e_instr = i_;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        en = v.en; imem_rvalid = v.rv; imem_rdata = v.rdata;
        redirect = v.redir; redirect_pc = v.rpc; instr_ready = v.rdy;
    endtask

    initial begin
        logic [31:0] ei;
        //             en rv rdata  rd rpc          rdy| req addr        vld chk pc           instr
        // streaming with zero-wait memory
        tbl.push_back(mk(1,0,0,    0,0,           1,  0,32'h0,       0,1,32'h0,       0));
        tbl.push_back(mk(1,1,W0,   0,0,           1,  1,32'h0,       0,1,32'h0,       0));
        tbl.push_back(mk(1,1,W1,   0,0,           1,  1,32'h4,       1,1,32'h0,       W0));
        tbl.push_back(mk(1,1,W2,   0,0,           1,  1,32'h8,       1,1,32'h4,       W1));
        // back-pressure: two entries fill, no further request
        tbl.push_back(mk(1,1,W3,   0,0,           0,  1,32'hC,       1,1,32'h8,       W2));
        tbl.push_back(mk(1,0,0,    0,0,           0,  0,32'h10,      1,1,32'h8,       W2));
        tbl.push_back(mk(1,0,0,    0,0,           0,  0,32'h10,      1,1,32'h8,       W2));
        tbl.push_back(mk(1,0,0,    0,0,           1,  0,32'h10,      1,1,32'h8,       W2));
        tbl.push_back(mk(1,0,0,    0,0,           1,  1,32'h10,      1,1,32'hC,       W3));
        // redirect with request outstanding -> DROP, stale response swallowed
        tbl.push_back(mk(1,0,0,    1,32'h103,     1,  1,32'h10,      0,1,32'h0,       0));
        tbl.push_back(mk(1,0,0,    0,0,           1,  0,32'h100,     0,1,32'h0,       0));
        tbl.push_back(mk(1,1,BAD,  0,0,           1,  0,32'h100,     0,1,32'h0,       0));
        tbl.push_back(mk(1,0,0,    0,0,           1,  0,32'h100,     0,1,32'h0,       0));
        tbl.push_back(mk(1,1,W0,   0,0,           0,  1,32'h100,     0,1,32'h0,       0));
        // redirect coincident with rvalid, flush beats pop
        tbl.push_back(mk(1,1,W1,   1,32'h200,     1,  1,32'h104,     1,1,32'h100,     W0));
        tbl.push_back(mk(1,0,0,    0,0,           1,  0,32'h200,     0,1,32'h0,       0));
        tbl.push_back(mk(1,1,W2,   0,0,           1,  1,32'h200,     0,1,32'h0,       0));
        // en low mid-request: held req completes, no new req, valid gated
        tbl.push_back(mk(0,0,0,    0,0,           1,  1,32'h204,     0,0,32'h0,       0));
        tbl.push_back(mk(0,1,W3,   0,0,           1,  1,32'h204,     0,0,32'h0,       0));
        tbl.push_back(mk(0,0,0,    0,0,           1,  0,32'h208,     0,0,32'h0,       0));
        tbl.push_back(mk(1,0,0,    0,0,           0,  0,32'h208,     1,1,32'h200,     W2));
        tbl.push_back(mk(1,0,0,    0,0,           1,  0,32'h208,     1,1,32'h200,     W2));
        tbl.push_back(mk(1,1,W0,   0,0,           1,  1,32'h208,     1,1,32'h204,     W3));
        tbl.push_back(mk(1,0,0,    0,0,           1,  1,32'h20C,     1,1,32'h208,     W0));
        tbl.push_back(mk(1,0,0,    0,0,           1,  1,32'h20C,     0,1,32'h0,       0));
        // redirects inside DROP, then PC wrap past 0xFFFFFFFC
        tbl.push_back(mk(1,0,0,    1,32'hFFFFFFFE,1,  1,32'h20C,     0,1,32'h0,       0));
        tbl.push_back(mk(1,0,0,    1,32'h300,     1,  0,32'hFFFFFFFC,0,1,32'h0,       0));
        tbl.push_back(mk(1,1,BAD,  1,32'hFFFFFFFE,1,  0,32'h300,     0,1,32'h0,       0));
        tbl.push_back(mk(1,0,0,    0,0,           1,  0,32'hFFFFFFFC,0,1,32'h0,       0));
        tbl.push_back(mk(1,1,W1,   0,0,           1,  1,32'hFFFFFFFC,0,1,32'h0,       0));
        tbl.push_back(mk(1,0,0,    0,0,           1,  1,32'h0,       1,1,32'hFFFFFFFC,W1));

        // reset state
        rst = 1'b1; en = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   -1, 32'(imem_req), 0);
        check("rst_addr",  -1, imem_addr, 32'h0);
        check("rst_vld",   -1, 32'(instr_valid), 0);
        check("rst_instr", -1, instr, 0);
        check("rst_pc",    -1, instr_pc, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            if (i != 0) @(negedge clk);
            apply(tbl[i]);
            #1;
            check("imem_req",    i, 32'(imem_req), 32'(tbl[i].e_req));
            check("imem_addr",   i, imem_addr, tbl[i].e_addr);
            check("instr_valid", i, 32'(instr_valid), 32'(tbl[i].e_vld));
            if (tbl[i].e_chk) begin
                ei = tbl[i].e_instr;
                check("instr",    i, instr, ei);
                check("instr_pc", i, instr_pc, tbl[i].e_pc);
                check("op",       i, 32'(op), 32'(ei[6:0]));
                check("funct3",   i, 32'(funct3), 32'(ei[14:12]));
                check("funct7",   i, 32'(funct7), 32'(ei[30]));
            end
        end

        // Reset mid-request with a buffered entry: everything clears at once.
        @(negedge clk);
        en = 1'b1; imem_rvalid = 1'b1; imem_rdata = W2; instr_ready = 1'b0; redirect = 1'b0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        check("pre_rst_req", 100, 32'(imem_req), 1);
        check("pre_rst_addr", 100, imem_addr, 32'h4);
        check("pre_rst_vld", 100, 32'(instr_valid), 1);
        check("pre_rst_instr", 100, instr, W2);
        #1 rst = 1'b1;
        #1;
        check("async_rst_req",   101, 32'(imem_req), 0);
        check("async_rst_addr",  101, imem_addr, 32'h0);
        check("async_rst_vld",   101, 32'(instr_valid), 0);
        check("async_rst_instr", 101, instr, 0);
        check("async_rst_pc",    101, instr_pc, 0);
        check("async_rst_op",    101, 32'(op), 0);
        // Late response arrives after reset in IDLE: must be ignored.
        @(negedge clk);
        rst = 1'b0; en = 1'b0; imem_rvalid = 1'b1; imem_rdata = W3;
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
        check("late_rv_vld", 102, 32'(instr_valid), 0);
        check("late_rv_req", 102, 32'(imem_req), 0);
        en = 1'b1;
        #1;
        check("late_rv_empty", 103, 32'(instr_valid), 0);
        @(negedge clk);
        #1;
        check("post_rst_req",  104, 32'(imem_req), 1);
        check("post_rst_addr", 104, imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
